// File: rtl/alu_cmd_sequencer_if.sv
// Command / response handshake bundle between an upstream command source
// and the ALU command sequencer. The sequencer uses the slave view; the
// producer of commands and consumer of responses uses the master view.
interface alu_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [2:0] cmd_sel;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_out;
   logic [4:0] rsp_flags;
   logic [2:0] rsp_sel;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_sel
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
      output cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_sel
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: buffers {a, b, select} commands in a small circular
// FIFO, issues them one at a time to an external combinational ALU, holds the
// operands for a settle window, then captures the ALU result and flags into a
// valid/ready response register. Responses leave in acceptance order.
module alu_cmd_sequencer #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_cmd_sequencer_if.slave bus,
   output logic [3:0]         alu_a,
   output logic [3:0]         alu_b,
   output logic [2:0]         alu_select,
   input  logic [3:0]         alu_out,
   input  logic               alu_carry,
   input  logic               alu_overflow,
   input  logic               alu_parity,
   input  logic               alu_zero,
   input  logic               alu_sign,
   output logic               busy,
   output logic [CNT_W-1:0]   op_count,
   output logic [CNT_W-1:0]   ovf_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int CW = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

   // FIFO storage and pointers; the extra pointer MSB separates full from empty.
   logic [CW-1:0] fifo_mem_r [DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic [CW-1:0] head_s;

   // Sequencer state and registered outputs.
   state_t        state_r;
   logic [SW-1:0] settle_cnt_r;
   logic [3:0]    alu_a_r;
   logic [3:0]    alu_b_r;
   logic [2:0]    alu_select_r;
   logic          rsp_valid_r;
   logic [3:0]    rsp_out_r;
   logic [4:0]    rsp_flags_r;
   logic [2:0]    rsp_sel_r;
   logic [CNT_W-1:0] op_count_r;
   logic [CNT_W-1:0] ovf_count_r;

   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign push_s  = bus.cmd_valid && !full_s;
   // The head is only consumed from IDLE, which gives the one-cycle bubble per op.
   assign pop_s   = (state_r == ST_IDLE) && !empty_s;
   assign head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];

   // Write accepted commands into the slot addressed by the write pointer.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r[AW-1:0]] <= {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
      end
   end

   // Advance the FIFO pointers on push and pop; reset empties the queue.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   // Issue / settle / respond sequencer with all of its registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         settle_cnt_r <= '0;
         alu_a_r      <= 4'd0;
         alu_b_r      <= 4'd0;
         alu_select_r <= 3'd0;
         rsp_valid_r  <= 1'b0;
         rsp_out_r    <= 4'd0;
         rsp_flags_r  <= 5'd0;
         rsp_sel_r    <= 3'd0;
         op_count_r   <= '0;
         ovf_count_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!empty_s) begin
                  alu_a_r      <= head_s[10:7];
                  alu_b_r      <= head_s[6:3];
                  alu_select_r <= head_s[2:0];
                  settle_cnt_r <= SW'(SETTLE);
                  state_r      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Capture on the edge where the settle count would reach zero.
               if (settle_cnt_r == SW'(1)) begin
                  settle_cnt_r <= '0;
                  rsp_out_r    <= alu_out;
                  rsp_flags_r  <= {alu_carry, alu_overflow, alu_parity, alu_zero, alu_sign};
                  rsp_sel_r    <= alu_select_r;
                  rsp_valid_r  <= 1'b1;
                  state_r      <= ST_RESP;
               end else begin
                  settle_cnt_r <= settle_cnt_r - SW'(1);
               end
            end
            ST_RESP: begin
               // Response is held untouched until the consumer takes it.
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  op_count_r  <= sat_inc(op_count_r);
                  if (rsp_flags_r[3]) begin
                     ovf_count_r <= sat_inc(ovf_count_r);
                  end
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready = !full_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_out   = rsp_out_r;
   assign bus.rsp_flags = rsp_flags_r;
   assign bus.rsp_sel   = rsp_sel_r;
   assign alu_a         = alu_a_r;
   assign alu_b         = alu_b_r;
   assign alu_select    = alu_select_r;
   assign busy          = (state_r != ST_IDLE) || !empty_s;
   assign op_count      = op_count_r;
   assign ovf_count     = ovf_count_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: drives commands through a behavioural 4-bit
// ALU, follows the block with a queue-based transaction model, and adds a
// constant vector table plus hand-written multi-cycle sequences.
module tb_alu_cmd_sequencer;
   localparam int DEPTH  = 4;
   localparam int SETTLE = 1;
   localparam int CNT_W  = 2;
   localparam int MAXC   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] alu_a, alu_b, alu_out;
   logic [2:0] alu_select;
   logic alu_carry, alu_overflow, alu_parity, alu_zero, alu_sign;
   logic busy;
   logic [CNT_W-1:0] op_count, ovf_count;

   alu_cmd_sequencer_if bus ();

   alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
      .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .alu_parity(alu_parity), .alu_zero(alu_zero), .alu_sign(alu_sign),
      .busy(busy), .op_count(op_count), .ovf_count(ovf_count)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {out[3:0], carry, overflow, parity, zero, sign}.
   function automatic logic [8:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
      logic [4:0] w;
      logic [3:0] r;
      logic c, v;
      int sa, sb, p;
      sa = int'($signed(a));
      sb = int'($signed(b));
      c = 1'b0; v = 1'b0; r = 4'd0; p = 0;
      case (s)
         3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
         3'd1: begin r = a - b; c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
         3'd2: begin p = sa * sb; r = p[3:0]; v = (p > 7) || (p < -8); end
         3'd3: begin
            if (b == 4'd0) begin r = 4'd0; v = 1'b1; end
            else begin p = sa / sb; r = p[3:0]; v = (p > 7); end
         end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = ~a;
      endcase
      return {r, c, v, ^r, (r == 4'd0), r[3]};
   endfunction

   assign {alu_out, alu_carry, alu_overflow, alu_parity, alu_zero, alu_sign} =
          alu_ref(alu_a, alu_b, alu_select);

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // Transaction model: queued commands, the op in flight, and when its response appears.
   logic [10:0] mq[$];
   bit          have_cur = 1'b0;
   logic [10:0] cur = 11'd0;
   int          valid_at = 0;
   logic [10:0] m_alu = 11'd0;
   int          m_op = 0;
   int          m_ovf = 0;
   bit          last_hs, dut_push, dut_hs;
   logic [3:0]  seen_out;
   logic [4:0]  seen_flags;
   logic [2:0]  seen_sel;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive inputs, advance the model by the rules, compare after the edge.
   task automatic step(input bit rstv, input bit cv, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] sel, input bit rr);
      bit m_rv;
      bit do_pop, do_push;
      logic [8:0] e;
      rst_n = rstv;
      bus.cmd_valid = cv; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_sel = sel;
      bus.rsp_ready = rr;
      dut_push = bus.cmd_valid && bus.cmd_ready;
      dut_hs   = bus.rsp_valid && rr;
      last_hs  = 1'b0;
      m_rv = have_cur && (cyc >= valid_at);
      if (m_rv && rr) begin
         seen_out = bus.rsp_out; seen_flags = bus.rsp_flags; seen_sel = bus.rsp_sel;
      end
      if (!rstv) begin
         mq.delete(); have_cur = 1'b0; m_alu = 11'd0; m_op = 0; m_ovf = 0;
      end else begin
         do_pop  = !have_cur && (mq.size() > 0);
         do_push = cv && (mq.size() < DEPTH);
         if (m_rv && rr) begin
            e = alu_ref(cur[10:7], cur[6:3], cur[2:0]);
            m_op = (m_op == MAXC) ? MAXC : m_op + 1;
            if (e[3]) m_ovf = (m_ovf == MAXC) ? MAXC : m_ovf + 1;
            have_cur = 1'b0;
            last_hs = 1'b1;
         end
         if (do_pop) begin
            cur = mq.pop_front(); have_cur = 1'b1; m_alu = cur;
            valid_at = cyc + 1 + SETTLE;
         end
         if (do_push) mq.push_back({a, b, sel});
      end
      @(posedge clk);
      cyc++;
      #1;
      m_rv = have_cur && (cyc >= valid_at);
      chk("cmd_ready", bus.cmd_ready, mq.size() < DEPTH);
      chk("busy", busy, have_cur || (mq.size() > 0));
      chk("rsp_valid", bus.rsp_valid, m_rv);
      chk("alu_a", alu_a, m_alu[10:7]);
      chk("alu_b", alu_b, m_alu[6:3]);
      chk("alu_select", alu_select, m_alu[2:0]);
      chk("op_count", op_count, m_op);
      chk("ovf_count", ovf_count, m_ovf);
      if (m_rv) begin
         e = alu_ref(cur[10:7], cur[6:3], cur[2:0]);
         chk("rsp_out", bus.rsp_out, e[8:5]);
         chk("rsp_flags", bus.rsp_flags, e[4:0]);
         chk("rsp_sel", bus.rsp_sel, cur[2:0]);
      end
   endtask

   task automatic idle(input bit rr);
      step(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, rr);
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] sel;
      logic [3:0] out;
      logic [4:0] flags;   // {carry, overflow, parity, zero, sign}
   } vec_t;

   vec_t vecs[10];

   initial begin
      bit got;
      int n_acc, n_rsp, n_seen;
      logic [10:0] sent[$];
      logic [8:0] e;

      vecs[0] = '{4'b0111, 4'b0001, 3'd0, 4'b1000, 5'b01101};
      vecs[1] = '{4'b0101, 4'b0011, 3'd4, 4'b0001, 5'b00100};
      vecs[2] = '{4'b0101, 4'b0011, 3'd5, 4'b0111, 5'b00100};
      vecs[3] = '{4'b0101, 4'b0011, 3'd6, 4'b0110, 5'b00000};
      vecs[4] = '{4'b0101, 4'b0011, 3'd7, 4'b1010, 5'b00001};
      vecs[5] = '{4'b0011, 4'b0101, 3'd1, 4'b1110, 5'b10101};
      vecs[6] = '{4'b1000, 4'b1000, 3'd0, 4'b0000, 5'b11010};
      vecs[7] = '{4'b0011, 4'b0011, 3'd2, 4'b1001, 5'b01001};
      vecs[8] = '{4'b0110, 4'b1110, 3'd3, 4'b1101, 5'b00101};
      vecs[9] = '{4'b0101, 4'b0000, 3'd3, 4'b0000, 5'b01010};

      bus.cmd_valid = 1'b0; bus.cmd_a = 4'd0; bus.cmd_b = 4'd0; bus.cmd_sel = 3'd0;
      bus.rsp_ready = 1'b0;

      // Reset held two cycles with a command offered: nothing may be taken.
      step(1'b0, 1'b1, 4'd3, 4'd4, 3'd0, 1'b0);
      step(1'b0, 1'b1, 4'd3, 4'd4, 3'd0, 1'b0);
      chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_out", bus.rsp_out, 4'd0);
      chk("rst_rsp_flags", bus.rsp_flags, 5'd0);
      chk("rst_rsp_sel", bus.rsp_sel, 3'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_counts", {op_count, ovf_count}, '0);
      idle(1'b1);
      chk("rst_nothing_queued", busy, 1'b0);

      // Vector table: one op at a time, response compared with constant expectations.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sel, 1'b1);
         if (i == 0) begin
            idle(1'b1);
            chk("lat_not_yet", bus.rsp_valid, 1'b0);
            idle(1'b1);
            chk("lat_valid", bus.rsp_valid, 1'b1);
         end
         got = 1'b0;
         for (int k = 0; k < 20 && !got; k++) begin
            idle(1'b1);
            got = last_hs;
         end
         chk("vec_done", got, 1'b1);
         chk($sformatf("vec%0d_out", i), seen_out, vecs[i].out);
         chk($sformatf("vec%0d_flags", i), seen_flags, vecs[i].flags);
         chk($sformatf("vec%0d_sel", i), seen_sel, vecs[i].sel);
         if (i == 0) begin
            chk("add_op_count", op_count, 1);
            chk("add_ovf_count", ovf_count, 1);
            step(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
         end
         if (i == 4) chk("logic_ovf_count", ovf_count, 0);
      end

      // Stall: seven back-to-back offers with no consumer, then drain in order.
      step(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      n_acc = 0;
      sent.delete();
      for (int j = 0; j < 7; j++) begin
         step(1'b1, 1'b1, 4'(j + 1), 4'(9 - j), 3'(j), 1'b0);
         if (dut_push) begin
            n_acc++;
            sent.push_back({4'(j + 1), 4'(9 - j), 3'(j)});
         end
      end
      chk("stall_accepted", n_acc, 5);
      chk("stall_cmd_ready", bus.cmd_ready, 1'b0);
      for (int j = 0; j < 4; j++) idle(1'b0);
      n_rsp = 0;
      for (int k = 0; k < 40 && n_rsp < 5; k++) begin
         idle(1'b1);
         if (dut_hs) begin
            e = (sent.size() > 0) ? alu_ref(sent[0][10:7], sent[0][6:3], sent[0][2:0]) : 9'd0;
            chk("stall_order_sel", seen_sel, (sent.size() > 0) ? sent[0][2:0] : 3'd0);
            chk("stall_order_out", seen_out, e[8:5]);
            if (sent.size() > 0) void'(sent.pop_front());
            n_rsp++;
         end
      end
      chk("stall_responses", n_rsp, 5);

      // Reset mid-operation with a response pending and two commands queued.
      step(1'b1, 1'b1, 4'd1, 4'd1, 3'd0, 1'b0);
      step(1'b1, 1'b1, 4'd2, 4'd2, 3'd1, 1'b0);
      step(1'b1, 1'b1, 4'd3, 4'd3, 3'd2, 1'b0);
      chk("mid_pre_valid", bus.rsp_valid, 1'b1);
      step(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
      chk("mid_rsp_valid", bus.rsp_valid, 1'b0);
      chk("mid_busy", busy, 1'b0);
      chk("mid_counts", {op_count, ovf_count}, '0);
      n_seen = 0;
      for (int k = 0; k < 20; k++) begin
         idle(1'b1);
         if (bus.rsp_valid) n_seen++;
      end
      chk("mid_no_late_rsp", n_seen, 0);

      // Five overflowing adds against 2-bit counters: both must stick at 3.
      for (int j = 0; j < 5; j++) step(1'b1, 1'b1, 4'b0111, 4'b0001, 3'd0, 1'b1);
      n_rsp = 0;
      for (int k = 0; k < 60 && busy; k++) idle(1'b1);
      chk("sat_drained", busy, 1'b0);
      chk("sat_op_count", op_count, 3);
      chk("sat_ovf_count", ovf_count, 3);

      // Random traffic with random back-pressure and occasional reset.
      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(63) != 0), ($urandom_range(2) != 0),
              4'($urandom_range(15)), 4'($urandom_range(15)), 3'($urandom_range(7)),
              ($urandom_range(3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
